btn_debounce_reader: RTL and testbench

//  Input-side companion to the on-board RGB LED drivers: samples one raw active-low push-button.

---
 rtl/btn_debounce_reader_if.sv | 21 ++
 rtl/btn_debounce_reader.sv | 169 ++++++++++++++++
 tb/tb_btn_debounce_reader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_reader_if.sv
// Button event bundle: raw active-low input plus debounced level and single-cycle event strobes.
// The master side is the debouncer. The slave side is the consumer that also owns the raw pin.
interface btn_debounce_reader_if;
    logic btn_n;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;

    modport master (
        input  btn_n,
        output btn_level, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse
    );

    modport slave (
        output btn_n,
        input  btn_level, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/btn_debounce_reader.sv
// Synchronises, debounces and classifies one active-low push-button into press/release/short/long/repeat strobes.
// Latency: raw edge to press/release strobe is DEBOUNCE_CYC+3 cycles. Outputs are registered and there is no backpressure.
module btn_debounce_reader #(
    parameter int DEBOUNCE_CYC = 270_000,
    parameter int LONG_CYC     = 27_000_000,
    parameter int REPEAT_CYC   = 6_750_000,
    parameter int CNT_W        = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    btn_debounce_reader_if.master btn_if
);

    typedef enum logic [1:0] {
        ST_RELEASED   = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             long_done_q, long_done_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             btn_s;
    logic             db_done;

    assign btn_s   = ~sync2_q;
    assign db_done = (db_cnt_q == DB_LAST);

    // Synchroniser resets to the released level so reset never looks like a press edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= ST_RELEASED;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync1_q     <= btn_if.btn_n;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            short_q     <= short_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    // A completed debounce count takes priority over a simultaneous input change.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        long_done_d = long_done_q;
        case (state_q)
            ST_RELEASED: begin
                if (btn_s) begin
                    state_d  = ST_PRESS_DB;
                    db_cnt_d = '0;
                end
            end
            ST_PRESS_DB: begin
                if (db_done) begin
                    state_d     = ST_PRESSED;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else if (!btn_s) begin
                    state_d = ST_RELEASED;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!long_done_q) begin
                    if (hold_cnt_q == LONG_LAST) begin
                        long_done_d = 1'b1;
                        rep_cnt_d   = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
                end else if (rep_cnt_q == REP_LAST) begin
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + CNT_ONE;
                end
                if (!btn_s) begin
                    state_d  = ST_RELEASE_DB;
                    db_cnt_d = '0;
                end
            end
            ST_RELEASE_DB: begin
                if (db_done) begin
                    state_d = ST_RELEASED;
                end else if (btn_s) begin
                    state_d = ST_PRESSED;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_RELEASED;
        endcase
    end

    always_comb begin
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_PRESS_DB: begin
                if (db_done) begin
                    press_d = 1'b1;
                    level_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                long_d   = !long_done_q && (hold_cnt_q == LONG_LAST);
                repeat_d = long_done_q && (rep_cnt_q == REP_LAST);
            end
            ST_RELEASE_DB: begin
                if (db_done) begin
                    release_d = 1'b1;
                    short_d   = !long_done_q;
                    level_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign btn_if.btn_level     = level_q;
    assign btn_if.press_pulse   = press_q;
    assign btn_if.release_pulse = release_q;
    assign btn_if.short_pulse   = short_q;
    assign btn_if.long_pulse    = long_q;
    assign btn_if.repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_btn_debounce_reader.sv
// Directed bench for btn_debounce_reader with short timing parameters; edge numbers are counted from the
// posedge after which btn_n is changed, and outputs are sampled 1 time unit after each posedge.
module tb_btn_debounce_reader;

    logic sys_clk;
    logic sys_rst_n;

    btn_debounce_reader_if bif ();

    btn_debounce_reader #(
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (20),
        .REPEAT_CYC   (5),
        .CNT_W        (32)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .btn_if    (bif)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;
    int n_press, n_release, n_short, n_long, n_repeat;
    int last_press, last_release, last_short, last_long, first_repeat, last_repeat;
    int level_seen;
    int excl_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clr();
        cyc = 0;
        n_press = 0; n_release = 0; n_short = 0; n_long = 0; n_repeat = 0;
        last_press = -1; last_release = -1; last_short = -1; last_long = -1;
        first_repeat = -1; last_repeat = -1;
        level_seen = 0;
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
        if (bif.press_pulse)   begin n_press++;   last_press   = cyc; end
        if (bif.release_pulse) begin n_release++; last_release = cyc; end
        if (bif.short_pulse)   begin n_short++;   last_short   = cyc; end
        if (bif.long_pulse)    begin n_long++;    last_long    = cyc; end
        if (bif.repeat_pulse) begin
            if (n_repeat == 0) first_repeat = cyc;
            n_repeat++;
            last_repeat = cyc;
        end
        if (bif.press_pulse && bif.release_pulse) excl_err++;
        if (bif.long_pulse && bif.repeat_pulse)   excl_err++;
        if (bif.btn_level) level_seen = 1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int outs();
        return {26'd0, bif.btn_level, bif.press_pulse, bif.release_pulse,
                bif.short_pulse, bif.long_pulse, bif.repeat_pulse};
    endfunction

    initial begin
        sys_rst_n = 1'b0;
        bif.btn_n = 1'b1;
        clr();
        #12;
        chk("reset_outputs", outs(), 0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        steps(10);
        chk("idle_no_events", n_press + n_release + n_long, 0);

        // Clean short press
        clr();
        bif.btn_n = 1'b0;
        steps(15);
        chk("t1_press_cnt", n_press, 1);
        chk("t1_press_edge", last_press, 7);
        chk("t1_level_hi", bif.btn_level, 1);
        bif.btn_n = 1'b1;
        steps(12);
        chk("t1_release_edge", last_release, 22);
        chk("t1_short_edge", last_short, 22);
        chk("t1_release_cnt", n_release, 1);
        chk("t1_no_long", n_long, 0);
        chk("t1_level_lo", bif.btn_level, 0);

        // Bounce shorter than the debounce window
        clr();
        bif.btn_n = 1'b0; steps(3);
        bif.btn_n = 1'b1; steps(2);
        bif.btn_n = 1'b0; steps(2);
        bif.btn_n = 1'b1; steps(12);
        chk("t2_no_press", n_press, 0);
        chk("t2_no_release", n_release, 0);
        chk("t2_level_never", level_seen, 0);

        // Long hold with auto-repeat
        clr();
        bif.btn_n = 1'b0;
        steps(57);
        bif.btn_n = 1'b1;
        steps(13);
        chk("t3_press_edge", last_press, 7);
        chk("t3_long_cnt", n_long, 1);
        chk("t3_long_edge", last_long, 27);
        chk("t3_first_repeat", first_repeat, 32);
        chk("t3_repeat_cnt", n_repeat, 6);
        chk("t3_last_repeat", last_repeat, 57);
        chk("t3_release_edge", last_release, 64);
        chk("t3_no_short", n_short, 0);
        chk("t3_level_lo", bif.btn_level, 0);

        // Release glitch while pressed; hold counting freezes during the glitch
        clr();
        bif.btn_n = 1'b0; steps(10);
        bif.btn_n = 1'b1; steps(2);
        bif.btn_n = 1'b0; steps(6);
        chk("t4_no_release", n_release, 0);
        chk("t4_single_press", n_press, 1);
        chk("t4_level_hi", bif.btn_level, 1);
        steps(14);
        chk("t4_long_edge", last_long, 29);
        bif.btn_n = 1'b1;
        steps(13);
        chk("t4_repeat_edge", last_repeat, 34);
        chk("t4_release_edge", last_release, 39);
        chk("t4_no_short", n_short, 0);

        // Asynchronous reset during a hold, button kept low through deassertion
        clr();
        bif.btn_n = 1'b0;
        steps(7);
        chk("t5_press_before_rst", bif.press_pulse, 1);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("t5_async_clear", outs(), 0);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("t5_held_in_reset", outs(), 0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        clr();
        steps(30);
        chk("t5_press_edge", last_press, 7);
        chk("t5_press_cnt", n_press, 1);
        chk("t5_long_cnt", n_long, 1);
        chk("t5_long_edge", last_long, 27);
        bif.btn_n = 1'b1;
        steps(12);
        chk("t5_release_edge", last_release, 37);
        chk("t5_no_short", n_short, 0);

        chk("exclusivity", excl_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
